jam_cost_server: RTL and testbench
==================================

// Module: jam_cost_server
// PURPOSE
//   Responder side of the JAM cost-query interface. Holds the 8x8 worker/job cost table,
//   answers each (W,J) query with a registered Cost one cycle later, and captures the final
//   MinCost/MatchCount on Valid. The table is streamed in over a valid/ready load port.
//   While the table is incomplete, the block holds the attached JAM in reset via jam_rst.
// PARAMETERS
//   N        8    workers = jobs; table holds N*N entries
//   IDX_W    3    width of W and J (log2 N)
//   COST_W   7    width of one cost entry
//   QCNT_W   16   width of query_count (saturating)
// PORTS
//   CLK           in   1       clock; all logic on rising edge
//   RST           in   1       synchronous, active-high reset
//   load_valid    in   1       load_data holds a valid table entry
//   load_data     in   COST_W  cost entry, row-major order: index = W*N + J
//   load_ready    out  1       entry accepted when load_valid && load_ready
//   jam_rst       out  1       reset for the JAM; high until the table is fully loaded
//   W             in   IDX_W   worker index queried by the JAM
//   J             in   IDX_W   job index queried by the JAM
//   Cost          out  COST_W  table[W][J] of the previous cycle's query
//   Valid         in   1       JAM result valid
//   MinCost       in   10      JAM minimum total cost
//   MatchCount    in   4       JAM count of minimum-cost assignments
//   done          out  1       result captured (sticky until RST)
//   result_cost   out  10      captured MinCost
//   result_count  out  4       captured MatchCount
//   query_count   out  QCNT_W  number of SERVE cycles (JAM queries issued)
// BEHAVIOUR
//   Reset values: state=LOAD, load_idx=0, load_ready=1, jam_rst=1, Cost=0, done=0,
//     result_cost=0, result_count=0, query_count=0. Table contents are not cleared by RST.
//   FSM states: LOAD -> SERVE -> DONE. DONE is left only through RST.
//   LOAD:
//     - load_ready=1 and jam_rst=1.
//     - On a handshake: table[load_idx] <= load_data and load_idx <= load_idx+1.
//     - When load_idx==N*N-1 is accepted: go to SERVE. load_ready and jam_rst fall on the next cycle.
//     - Cost=0. W, J and Valid are ignored.
//   SERVE:
//     - load_ready=0; load_valid is ignored and the table is unchanged.
//     - Cost <= table[W*N+J] every cycle: exactly 1-cycle registered latency.
//     - query_count += 1 per cycle, saturating at 2^QCNT_W-1.
//     - Valid=1: result_cost <= MinCost, result_count <= MatchCount, done <= 1, go to DONE.
//       The Cost lookup still occurs in that same cycle.
//   DONE:
//     - Results and done are held. Further Valid pulses do not recapture.
//     - Cost keeps serving lookups. query_count is frozen. jam_rst=0.
//   Index arithmetic: W*N+J is computed at width 2*IDX_W; there is no wrap or out-of-range case.
//   RST mid-load: load_idx returns to 0 and the reload starts from entry 0. Partial data is overwritten.
//   RST in SERVE/DONE: returns to LOAD, and the full table must be reloaded before jam_rst falls.
//   load_valid asserted together with RST: the entry is not written.
// TESTING
//   1 Load table[k]=k%128 for k=0..63. Next cycle: jam_rst=0, load_ready=0.
//     Drive W=3,J=5 -> next cycle Cost=29. Drive W=7,J=7 -> next cycle Cost=63.
//   2 Back-to-back queries W/J=0/0,0/1,0/2 on consecutive cycles
//     -> Cost=0,1,2 on the following three cycles.
//   3 In SERVE, load_valid=1, load_data=127 for 5 cycles -> load_ready=0 and table[0] still reads 0.
//   4 Load 10 entries, assert RST 1 cycle -> load_idx=0, jam_rst=1. 64 fresh entries are then
//     required before jam_rst=0. A query of W=0,J=0 returns the fresh entry 0.
//   5 In SERVE, Valid=1, MinCost=123, MatchCount=2 -> done=1, result_cost=123, result_count=2 next cycle.
//     A later Valid with MinCost=5 leaves result_cost=123.
//   6 Hold SERVE for 70000 cycles with no Valid -> query_count=65535 (saturated, no wrap).

Source files
------------

// File: rtl/jam_cost_if.sv
// Bundle of the JAM cost-query, table-load and result-capture signals.
// The master drives queries, loads and results; the slave is the cost server.
interface jam_cost_if #(
    parameter int IDX_W  = 3,
    parameter int COST_W = 7,
    parameter int QCNT_W = 16
);
    logic              load_valid;
    logic [COST_W-1:0] load_data;
    logic              load_ready;
    logic              jam_rst;
    logic [IDX_W-1:0]  W;
    logic [IDX_W-1:0]  J;
    logic [COST_W-1:0] Cost;
    logic              Valid;
    logic [9:0]        MinCost;
    logic [3:0]        MatchCount;
    logic              done;
    logic [9:0]        result_cost;
    logic [3:0]        result_count;
    logic [QCNT_W-1:0] query_count;

    modport master (
        output load_valid, load_data, W, J, Valid, MinCost, MatchCount,
        input  load_ready, jam_rst, Cost, done, result_cost, result_count, query_count
    );

    modport slave (
        input  load_valid, load_data, W, J, Valid, MinCost, MatchCount,
        output load_ready, jam_rst, Cost, done, result_cost, result_count, query_count
    );
endinterface

// File: rtl/jam_cost_server.sv
// Responder for the JAM cost-query interface: streams in an NxN cost table,
// serves registered lookups, and captures the final result when the JAM reports.
module jam_cost_server #(
    parameter int N      = 8,
    parameter int IDX_W  = 3,
    parameter int COST_W = 7,
    parameter int QCNT_W = 16
) (
    input  logic       CLK,
    input  logic       RST,
    jam_cost_if.slave  bus
);
    localparam int                 AW       = 2 * IDX_W;
    localparam logic [AW-1:0]      N_W      = AW'(N);
    localparam logic [AW-1:0]      LAST_IDX = AW'(N * N - 1);
    localparam logic [QCNT_W-1:0]  QCNT_MAX = {QCNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [COST_W-1:0]   table_r [0:N*N-1];
    logic [AW-1:0]       load_idx_r;
    logic                load_ready_r;
    logic                jam_rst_r;
    logic [COST_W-1:0]   cost_r;
    logic                done_r;
    logic [9:0]          result_cost_r;
    logic [3:0]          result_count_r;
    logic [QCNT_W-1:0]   query_count_r;
    logic                load_fire_s;
    logic [AW-1:0]       q_idx_s;

    assign load_fire_s = bus.load_valid && load_ready_r && (state_r == ST_LOAD);
    assign q_idx_s     = (AW'(bus.W) * N_W) + AW'(bus.J);

    // Next-state logic: LOAD until the last entry lands, SERVE until Valid, DONE until reset.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (load_fire_s && (load_idx_r == LAST_IDX)) begin
                    state_nxt_s = ST_SERVE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_SERVE: begin
                if (bus.Valid) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SERVE;
                end
            end
            ST_DONE:  state_nxt_s = ST_DONE;
            default:  state_nxt_s = ST_LOAD;
        endcase
    end

    // State register and all control/result registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r        <= ST_LOAD;
            load_idx_r     <= {AW{1'b0}};
            load_ready_r   <= 1'b1;
            jam_rst_r      <= 1'b1;
            cost_r         <= {COST_W{1'b0}};
            done_r         <= 1'b0;
            result_cost_r  <= 10'd0;
            result_count_r <= 4'd0;
            query_count_r  <= {QCNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            // Handshake flags drop one cycle after the final entry is accepted.
            load_ready_r <= (state_nxt_s == ST_LOAD);
            jam_rst_r    <= (state_nxt_s == ST_LOAD);
            if (load_fire_s) begin
                load_idx_r <= load_idx_r + AW'(1);
            end
            if (state_r == ST_LOAD) begin
                cost_r <= {COST_W{1'b0}};
            end else begin
                cost_r <= table_r[q_idx_s];
            end
            if ((state_r == ST_SERVE) && (query_count_r != QCNT_MAX)) begin
                query_count_r <= query_count_r + QCNT_W'(1);
            end
            if ((state_r == ST_SERVE) && bus.Valid) begin
                done_r         <= 1'b1;
                result_cost_r  <= bus.MinCost;
                result_count_r <= bus.MatchCount;
            end
        end
    end

    // Table storage survives reset; writes are blocked while RST is high.
    always_ff @(posedge CLK) begin
        if (!RST && load_fire_s) begin
            table_r[load_idx_r] <= bus.load_data;
        end
    end

    assign bus.load_ready   = load_ready_r;
    assign bus.jam_rst      = jam_rst_r;
    assign bus.Cost         = cost_r;
    assign bus.done         = done_r;
    assign bus.result_cost  = result_cost_r;
    assign bus.result_count = result_count_r;
    assign bus.query_count  = query_count_r;
endmodule

// File: tb/tb_jam_cost_server.sv
// Self-checking bench for jam_cost_server: directed scenarios plus random
// tables and queries, compared against a behavioural model of the table server.
module tb_jam_cost_server;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    // Reference model state
    int   ref_tab [64];
    int   m_phase;      // 0 = loading, 1 = serving, 2 = finished
    int   m_idx;
    int   m_cost;
    int   m_done;
    int   m_rc;
    int   m_rn;
    int   m_qc;
    int   saved0;

    jam_cost_if #(.IDX_W(3), .COST_W(7), .QCNT_W(16)) bus ();

    jam_cost_server #(.N(8), .IDX_W(3), .COST_W(7), .QCNT_W(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock, applying the spec's rules to the inputs present at the edge.
    task automatic step();
        if (rst) begin
            m_phase = 0; m_idx = 0; m_cost = 0; m_done = 0;
            m_rc = 0; m_rn = 0; m_qc = 0;
        end else if (m_phase == 0) begin
            m_cost = 0;
            if (bus.load_valid) begin
                ref_tab[m_idx] = int'(bus.load_data);
                if (m_idx == 63) m_phase = 1;
                m_idx = m_idx + 1;
            end
        end else begin
            m_cost = ref_tab[int'(bus.W) * 8 + int'(bus.J)];
            if (m_phase == 1) begin
                if (m_qc < 65535) m_qc = m_qc + 1;
                if (bus.Valid) begin
                    m_rc = int'(bus.MinCost);
                    m_rn = int'(bus.MatchCount);
                    m_done = 1;
                    m_phase = 2;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".load_ready"}, 32'(bus.load_ready), 32'(m_phase == 0));
        chk({tag, ".jam_rst"},    32'(bus.jam_rst),    32'(m_phase == 0));
        chk({tag, ".Cost"},       32'(bus.Cost),       32'(m_cost));
        chk({tag, ".done"},       32'(bus.done),       32'(m_done));
        chk({tag, ".result_cost"},  32'(bus.result_cost),  32'(m_rc));
        chk({tag, ".result_count"}, 32'(bus.result_count), 32'(m_rn));
        chk({tag, ".query_count"},  32'(bus.query_count),  32'(m_qc));
    endtask

    // Load n entries; mode 0 writes k%128 by table position, mode 1 random values.
    task automatic load_n(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = (mode == 0) ? 7'(m_idx % 128) : 7'($urandom_range(0, 127));
            step();
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic random_queries(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.W = 3'($urandom_range(0, 7));
            bus.J = 3'($urandom_range(0, 7));
            step();
            chk({tag, ".Cost"}, 32'(bus.Cost), 32'(m_cost));
        end
        check_all(tag);
    endtask

    initial begin
        compared = 0; mismatched = 0;
        m_phase = 0; m_idx = 0; m_cost = 0; m_done = 0; m_rc = 0; m_rn = 0; m_qc = 0;
        for (int i = 0; i < 64; i++) ref_tab[i] = 0;
        rst = 1'b1;
        bus.load_valid = 1'b0; bus.load_data = 7'd0;
        bus.W = 3'd0; bus.J = 3'd0;
        bus.Valid = 1'b0; bus.MinCost = 10'd0; bus.MatchCount = 4'd0;
        step();
        step();
        check_all("reset");
        chk("reset.load_ready_lit", 32'(bus.load_ready), 32'd1);
        rst = 1'b0;

        // Identity table; flags must stay high until the 64th entry is taken.
        load_n(63, 0);
        check_all("load63");
        load_n(1, 0);
        check_all("load64");
        chk("t1.jam_rst", 32'(bus.jam_rst), 32'd0);
        chk("t1.load_ready", 32'(bus.load_ready), 32'd0);
        bus.W = 3'd3; bus.J = 3'd5; step();
        chk("t1.cost35", 32'(bus.Cost), 32'd29);
        bus.W = 3'd7; bus.J = 3'd7; step();
        chk("t1.cost77", 32'(bus.Cost), 32'd63);

        // Back-to-back lookups
        for (int j = 0; j < 3; j++) begin
            bus.W = 3'd0; bus.J = 3'(j); step();
            chk("t2.b2b", 32'(bus.Cost), 32'(j));
        end

        // Loads ignored while serving
        for (int i = 0; i < 5; i++) begin
            bus.load_valid = 1'b1; bus.load_data = 7'd127; step();
            chk("t3.load_ready", 32'(bus.load_ready), 32'd0);
        end
        bus.load_valid = 1'b0;
        bus.W = 3'd0; bus.J = 3'd0; step();
        chk("t3.table0", 32'(bus.Cost), 32'd0);
        random_queries(20, "rq1");

        // Partial load then reset (with load_valid during reset); reload random table.
        rst = 1'b1; step(); rst = 1'b0;
        load_n(10, 1);
        rst = 1'b1; bus.load_valid = 1'b1; bus.load_data = 7'd99; step();
        rst = 1'b0; bus.load_valid = 1'b0;
        check_all("t4.rst");
        chk("t4.jam_rst", 32'(bus.jam_rst), 32'd1);
        load_n(63, 1);
        chk("t4.jam_rst63", 32'(bus.jam_rst), 32'd1);
        load_n(1, 1);
        chk("t4.jam_rst64", 32'(bus.jam_rst), 32'd0);
        saved0 = ref_tab[0];
        bus.W = 3'd0; bus.J = 3'd0; step();
        chk("t4.fresh0", 32'(bus.Cost), 32'(saved0));
        random_queries(40, "rq2");

        // Result capture and no recapture
        bus.Valid = 1'b1; bus.MinCost = 10'd123; bus.MatchCount = 4'd2;
        bus.W = 3'd2; bus.J = 3'd6; step();
        bus.Valid = 1'b0;
        check_all("t5.capture");
        chk("t5.done", 32'(bus.done), 32'd1);
        chk("t5.result_cost", 32'(bus.result_cost), 32'd123);
        chk("t5.result_count", 32'(bus.result_count), 32'd2);
        bus.Valid = 1'b1; bus.MinCost = 10'd5; bus.MatchCount = 4'd9; step();
        bus.Valid = 1'b0;
        chk("t5.hold_cost", 32'(bus.result_cost), 32'd123);
        random_queries(10, "rq3");

        // query_count saturation
        rst = 1'b1; step(); rst = 1'b0;
        load_n(64, 1);
        check_all("t6.start");
        for (int i = 0; i < 65534; i++) step();
        chk("t6.qc65534", 32'(bus.query_count), 32'd65534);
        step();
        chk("t6.qc65535", 32'(bus.query_count), 32'd65535);
        for (int i = 0; i < 70000 - 65535; i++) step();
        chk("t6.qc_sat", 32'(bus.query_count), 32'd65535);
        check_all("t6.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
